// File: rtl/credit_rx_demux.sv
// credit_rx_demux: receive end of the credit flit link.
// Buffers flits, steers the head by route, returns credits.
module credit_rx_demux #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [W-1:0]           i_data,
  output logic                   credit_out,
  output logic [W-1:0]           o_data,
  output logic [3:0]             o_valid,
  input  logic [3:0]             o_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          credit_q, credit_d;
  logic          ovf_q, ovf_d;
  logic          full, empty;
  logic          push, pop;
  logic [1:0]    route;

  assign full  = (occ_q == FULL);
  assign empty = (occ_q == '0);
  assign push  = i_valid && !full;

  assign o_data  = mem_q[rd_ptr_q];
  assign route   = o_data[W-1 -: 2];
  assign o_valid = empty ? 4'b0000 : (4'b0001 << route);
  assign pop     = |(o_valid & o_ready);

  assign occupancy  = occ_q;
  assign credit_out = credit_q;
  assign overflow   = ovf_q;

  // Next-state: pointers, occupancy, credit pulse, sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    credit_d = pop;
    ovf_d    = ovf_q | (i_valid & full);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state; reset flushes contents and drops pending credit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  // Flit storage; stale entries are harmless since occupancy gates them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule
